// File: rtl/mem_burst_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_burst_ctrl_pkg
// Shared definitions for the burst memory model: default bus widths, the
// wait-state counter width and the controller FSM state encoding.
// No ports.
// ----------------------------------------------------------------------------
package mem_burst_ctrl_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 30;
    localparam int DEF_MEM_DEPTH   = 65536;
    localparam int DEF_BURST_WIDTH = 4;

    // Wait states range over 0..15, so four bits always suffice.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_XFER = 3'd2,
        ST_STB  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_burst_ctrl_if
// Four-phase REQ/ACK memory bus between the layer controller (master) and
// the burst memory model (slave).
//   MEM_REQ, MEM_WRITE, ADDR, BURST_LEN, BYTE_EN, DATA_IN : master -> slave
//   DATA_OUT, DATA_STB, MEM_ACK_OUT, MEM_ERR              : slave -> master
// ----------------------------------------------------------------------------
interface mem_burst_ctrl_if
    import mem_burst_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH
) ();

    logic                    MEM_REQ;
    logic                    MEM_WRITE;
    logic [ADDR_WIDTH-1:0]   ADDR;
    logic [BURST_WIDTH-1:0]  BURST_LEN;
    logic [DATA_WIDTH/8-1:0] BYTE_EN;
    logic [DATA_WIDTH-1:0]   DATA_IN;
    logic [DATA_WIDTH-1:0]   DATA_OUT;
    logic                    DATA_STB;
    logic                    MEM_ACK_OUT;
    logic                    MEM_ERR;

    modport master (
        output MEM_REQ, MEM_WRITE, ADDR, BURST_LEN, BYTE_EN, DATA_IN,
        input  DATA_OUT, DATA_STB, MEM_ACK_OUT, MEM_ERR
    );

    modport slave (
        input  MEM_REQ, MEM_WRITE, ADDR, BURST_LEN, BYTE_EN, DATA_IN,
        output DATA_OUT, DATA_STB, MEM_ACK_OUT, MEM_ERR
    );

endinterface

// File: rtl/mem_burst_ctrl_be_array.sv
// ----------------------------------------------------------------------------
// mem_be_array
// Synchronous single-port word array with per-byte write enables.
//   CLK, RESETn : clock, async active-low reset (read register only)
//   i_we, i_be  : write strobe and lane enables
//   i_re        : read strobe; o_rdata updates on the next edge and holds
//   i_addr      : word index
//   i_wdata     : write data
//   o_rdata     : registered read data
// ----------------------------------------------------------------------------
module mem_be_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 65536,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [IDX_W-1:0]        i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // NOTE: storage has no reset; contents must survive RESETn and a reset
    // loop over the whole array would not map onto RAM.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_burst_ctrl.sv
// ----------------------------------------------------------------------------
// mem_burst_ctrl
// Simulation memory model serving one master over a four-phase REQ/ACK
// handshake, with bursts, byte-enabled writes, wait states and an
// out-of-range error response. Storage lives in mem_be_array.
//   CLK, RESETn : clock, async active-low reset
//   bus         : mem_burst_ctrl_if slave port (request in, data/ack out)
// ----------------------------------------------------------------------------
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            CLK,
    input  logic            RESETn,
    mem_burst_ctrl_if.slave bus
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_t                 r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
    logic [BURST_WIDTH-1:0] r_len, w_len_nxt;
    logic [BURST_WIDTH-1:0] r_k, w_k_nxt;
    logic                   r_write, w_write_nxt;
    logic [BE_W-1:0]        r_be, w_be_nxt;
    logic [WAIT_CNT_W-1:0]  r_wait, w_wait_nxt;
    logic                   r_stb, w_stb_nxt;
    logic                   r_ack, w_ack_nxt;
    logic                   r_err, w_err_nxt;

    logic [ADDR_WIDTH:0]    w_end;
    logic [ADDR_WIDTH-1:0]  w_word_addr;
    logic                   w_mem_we;
    logic                   w_mem_re;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic                   w_unused_addr_hi;

    // One extra bit so ADDR+BURST_LEN cannot wrap back into range.
    assign w_end       = {1'b0, bus.ADDR} + (ADDR_WIDTH+1)'(bus.BURST_LEN);
    assign w_word_addr = r_addr + ADDR_WIDTH'(r_k);
    // Upper bits are zero for any request that passed the range check.
    assign w_unused_addr_hi = ^(w_word_addr >> IDX_W);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_k     <= '0;
            r_write <= 1'b0;
            r_be    <= '0;
            r_wait  <= '0;
            r_stb   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_len   <= w_len_nxt;
            r_k     <= w_k_nxt;
            r_write <= w_write_nxt;
            r_be    <= w_be_nxt;
            r_wait  <= w_wait_nxt;
            r_stb   <= w_stb_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_k_nxt     = r_k;
        w_write_nxt = r_write;
        w_be_nxt    = r_be;
        w_wait_nxt  = r_wait;
        w_stb_nxt   = 1'b0;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.MEM_REQ) begin
                    w_addr_nxt  = bus.ADDR;
                    w_len_nxt   = bus.BURST_LEN;
                    w_write_nxt = bus.MEM_WRITE;
                    w_be_nxt    = bus.BYTE_EN;
                    w_k_nxt     = '0;
                    w_wait_nxt  = '0;
                    if (w_end >= DEPTH_EXT) begin
                        w_state_nxt = ST_ACK;
                        w_ack_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_XFER;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_XFER;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            ST_XFER: begin
                w_mem_we    = r_write;
                w_mem_re    = !r_write;
                w_stb_nxt   = 1'b1;
                w_state_nxt = ST_STB;
            end
            ST_STB: begin
                if (r_k == r_len) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_k_nxt     = r_k + 1'b1;
                    w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_XFER;
                end
            end
            ST_ACK: begin
                // A still-high MEM_REQ is the old request, never a new one.
                if (!bus.MEM_REQ) begin
                    w_ack_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    mem_be_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_word_addr[IDX_W-1:0]),
        .i_be    (r_be),
        .i_wdata (bus.DATA_IN),
        .o_rdata (w_rdata)
    );

    assign bus.DATA_OUT    = w_rdata;
    assign bus.DATA_STB    = r_stb;
    assign bus.MEM_ACK_OUT = r_ack;
    assign bus.MEM_ERR     = r_err;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_burst_ctrl
// Two instances of mem_burst_ctrl (64 words; 0 and 3 wait states) driven
// through their interfaces. A word-array reference model plus timing
// formulas give every expected value.
// ----------------------------------------------------------------------------
module tb_mem_burst_ctrl;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req  [2];
    logic        wr   [2];
    logic [29:0] addr [2];
    logic [3:0]  blen [2];
    logic [3:0]  be   [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        stb  [2];
    logic        ack  [2];
    logic        err  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_burst_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(30), .BURST_WIDTH(4)) u_if ();

        mem_burst_ctrl #(
            .DATA_WIDTH  (32),
            .ADDR_WIDTH  (30),
            .MEM_DEPTH   (DEPTH),
            .BURST_WIDTH (4),
            .WAIT_CYCLES ((gi == 0) ? 0 : 3)
        ) u_dut (
            .CLK    (clk),
            .RESETn (rst_n),
            .bus    (u_if)
        );

        assign u_if.MEM_REQ   = req[gi];
        assign u_if.MEM_WRITE = wr[gi];
        assign u_if.ADDR      = addr[gi];
        assign u_if.BURST_LEN = blen[gi];
        assign u_if.BYTE_EN   = be[gi];
        assign u_if.DATA_IN   = din[gi];
        assign dout[gi] = u_if.DATA_OUT;
        assign stb[gi]  = u_if.DATA_STB;
        assign ack[gi]  = u_if.MEM_ACK_OUT;
        assign err[gi]  = u_if.MEM_ERR;
    end

    // Reference model: word contents per instance.
    logic [31:0] mmem [2][DEPTH];
    logic [31:0] wq [16];
    logic [31:0] last_dout;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] lanes);
        logic [31:0] r = old_w;
        for (int l = 0; l < 4; l++) if (lanes[l]) r[8*l +: 8] = new_w[8*l +: 8];
        return r;
    endfunction

    // One complete transaction. Entered and left #1 after a posedge.
    // wq[k] supplies the write word k.
    task automatic txn(input int s, input bit w, input int a, input int bl,
                       input logic [3:0] b, input int hold);
        int  wc      = (s == 0) ? 0 : 3;
        bit  exp_err = (longint'(a) + longint'(bl)) >= DEPTH;
        int  nstb    = 0;
        int  t       = -1;
        bit  done    = 0;
        int  idx;
        logic [31:0] exp_rd = '0;
        req[s] = 1'b1; wr[s] = w; addr[s] = 30'(a); blen[s] = 4'(bl); be[s] = b; din[s] = wq[0];
        while (!done && t < 400) begin
            @(posedge clk); #1; t++;
            if (stb[s]) begin
                check("stb_time", 64'(t), 64'(wc + 1 + nstb * (wc + 2)));
                idx = a + nstb;
                if (idx >= 0 && idx < DEPTH && nstb < 16) begin
                    if (w) begin
                        mmem[s][idx] = merge(mmem[s][idx], wq[nstb], b);
                    end else begin
                        check("rd_data", 64'(dout[s]), 64'(mmem[s][idx]));
                        exp_rd    = mmem[s][idx];
                        last_dout = dout[s];
                    end
                end
                nstb++;
                if (nstb < 16) din[s] = wq[nstb];
            end
            if (ack[s]) done = 1;
        end
        check("ack_seen", 64'(done), 64'(1));
        check("ack_time", 64'(t), exp_err ? 64'(0) : 64'((bl + 1) * (wc + 2)));
        check("err", 64'(err[s]), 64'(exp_err));
        check("stb_count", 64'(nstb), exp_err ? 64'(0) : 64'(bl + 1));
        if (!w && !exp_err) check("rd_hold", 64'(dout[s]), 64'(exp_rd));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("ack_hold", 64'(ack[s]), 64'(1));
            check("no_stb_in_ack", 64'(stb[s]), 64'(0));
        end
        req[s] = 1'b0;
        @(posedge clk); #1;
        check("ack_clr", 64'(ack[s]), 64'(0));
        check("err_clr", 64'(err[s]), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nstb;
        int t;
        for (int s = 0; s < 2; s++) begin
            req[s] = 0; wr[s] = 0; addr[s] = '0; blen[s] = '0; be[s] = '0; din[s] = '0;
        end
        #22;
        for (int s = 0; s < 2; s++) begin
            check("rst_stb", 64'(stb[s]), 64'(0));
            check("rst_ack", 64'(ack[s]), 64'(0));
            check("rst_err", 64'(err[s]), 64'(0));
            check("rst_dout", 64'(dout[s]), 64'(0));
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Bring every word of both instances to a known value.
        for (int s = 0; s < 2; s++) begin
            for (int blk = 0; blk < 4; blk++) begin
                for (int k = 0; k < 16; k++) wq[k] = $urandom;
                txn(s, 1, blk * 16, 15, 4'hF, 0);
            end
        end

        // Single write then read, zero wait states.
        wq[0] = 32'hDEADBEEF;
        txn(0, 1, 5, 0, 4'hF, 0);
        txn(0, 0, 5, 0, 4'hF, 0);
        check("single_rd", 64'(last_dout), 64'(32'hDEADBEEF));

        // Byte-lane merge.
        wq[0] = 32'hDEADBEEF;
        txn(0, 1, 7, 0, 4'hF, 0);
        wq[0] = 32'h11223344;
        txn(0, 1, 7, 0, 4'b0101, 1);
        txn(0, 0, 7, 0, 4'hF, 0);
        check("byte_en_rd", 64'(last_dout), 64'(32'hDE22BE44));

        // Four-word burst write and read back.
        for (int k = 0; k < 4; k++) wq[k] = 32'(k + 1);
        txn(0, 1, 16, 3, 4'hF, 0);
        txn(0, 0, 16, 3, 4'hF, 2);
        check("burst_last", 64'(last_dout), 64'(4));

        // Range boundary: end at 63 is legal, end at 64 is rejected.
        for (int s = 0; s < 2; s++) begin
            wq[0] = $urandom; wq[1] = $urandom;
            txn(s, 1, 62, 1, 4'hF, 0);
            wq[0] = $urandom; wq[1] = $urandom;
            txn(s, 1, 63, 1, 4'hF, 0);
            txn(s, 0, 63, 0, 4'hF, 0);
            txn(s, 0, 30'h3FFF_FFFF, 1, 4'hF, 0);
        end

        // Three wait states, two-word read: pulses at 4 and 9.
        txn(1, 0, 20, 1, 4'hF, 0);

        // Reset during word 2 of a four-word write.
        for (int k = 0; k < 4; k++) wq[k] = $urandom;
        txn(0, 1, 40, 3, 4'hF, 0);
        for (int k = 0; k < 4; k++) wq[k] = $urandom;
        req[0] = 1; wr[0] = 1; addr[0] = 30'd40; blen[0] = 4'd3; be[0] = 4'hF; din[0] = wq[0];
        nstb = 0; t = 0;
        while (nstb < 2 && t < 50) begin
            @(posedge clk); #1; t++;
            if (stb[0]) begin
                mmem[0][40 + nstb] = wq[nstb];
                nstb++;
                din[0] = wq[nstb];
            end
        end
        check("rst_pre_stb", 64'(nstb), 64'(2));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_stb", 64'(stb[0]), 64'(0));
        check("abort_ack", 64'(ack[0]), 64'(0));
        check("abort_err", 64'(err[0]), 64'(0));
        check("abort_dout", 64'(dout[0]), 64'(0));
        req[0] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        txn(0, 0, 40, 3, 4'hF, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int s    = int'($urandom_range(0, 1));
            int w    = int'($urandom_range(0, 1));
            int bl   = int'($urandom_range(0, 15));
            int mode = int'($urandom_range(0, 9));
            int a;
            if (mode < 6)      a = int'($urandom_range(0, DEPTH - 1));
            else if (mode < 8) a = DEPTH - bl - int'($urandom_range(0, 1));
            else               a = (1 << 30) - 1 - int'($urandom_range(0, 3));
            for (int k = 0; k < 16; k++) wq[k] = $urandom;
            txn(s, w[0], a, bl, 4'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
